lockin_nco_cfg_scheduler: RTL and testbench



---
 rtl/lockin_nco_cfg_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_lockin_nco_cfg_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lockin_nco_cfg_scheduler.sv
// Transfers CPU lock-in configuration (phase increments, offsets, gain) into the
// NCO-bank write port once the inputs settle, writing only changed entries, then commits.

module lockin_nco_entry_cmp #(
  parameter int PW = 20
) (
  input  logic [PW-1:0] live_i,
  input  logic [PW-1:0] snap_i,
  input  logic [PW-1:0] shadow_i,
  output logic          live_ne_snap_o,
  output logic          live_ne_shadow_o,
  output logic          snap_ne_shadow_o
);
  assign live_ne_snap_o   = (live_i != snap_i);
  assign live_ne_shadow_o = (live_i != shadow_i);
  assign snap_ne_shadow_o = (snap_i != shadow_i);
endmodule

module lockin_nco_cfg_scheduler #(
  parameter int NCH    = 8,
  parameter int PW     = 20,
  parameter int GW     = 6,
  parameter int SETTLE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH*PW-1:0]       incr_in,
  input  logic [NCH*PW-1:0]       offs_in,
  input  logic [GW-1:0]           gain_in,
  input  logic                    force_all,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [$clog2(NCH)-1:0]  wr_ch,
  output logic                    wr_sel,
  output logic [PW-1:0]           wr_data,
  output logic                    commit,
  output logic [GW-1:0]           gain_out,
  output logic                    busy
);
  localparam int NE = 2 * NCH;
  localparam int CW = $clog2(NCH);
  localparam int EW = $clog2(NE);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_SCAN, ST_WRITE, ST_COMMIT
  } state_t;

  state_t                  state_q, state_d;
  logic [NE-1:0][PW-1:0]   snap_q, snap_d;
  logic [NE-1:0][PW-1:0]   shd_q, shd_d;
  logic [GW-1:0]           snap_gain_q, snap_gain_d;
  logic [GW-1:0]           shd_gain_q, shd_gain_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [EW-1:0]           e_q, e_d;
  logic                    force_q, force_d;
  logic                    written_q, written_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [CW-1:0]           wr_ch_q, wr_ch_d;
  logic                    wr_sel_q, wr_sel_d;
  logic [PW-1:0]           wr_data_q, wr_data_d;
  logic                    commit_q, commit_d;
  logic [GW-1:0]           gain_out_q, gain_out_d;

  // Entry e interleaves channel e>>1's increment (even) and offset (odd).
  logic [NE-1:0][PW-1:0]   live;
  logic [NE-1:0]           d_live_snap, d_live_shd, d_snap_shd;

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign live[2*k]   = incr_in[k*PW +: PW];
    assign live[2*k+1] = offs_in[k*PW +: PW];
  end

  for (genvar e = 0; e < NE; e++) begin : g_cmp
    lockin_nco_entry_cmp #(.PW(PW)) u_cmp (
      .live_i           (live[e]),
      .snap_i           (snap_q[e]),
      .shadow_i         (shd_q[e]),
      .live_ne_snap_o   (d_live_snap[e]),
      .live_ne_shadow_o (d_live_shd[e]),
      .snap_ne_shadow_o (d_snap_shd[e])
    );
  end

  logic live_vs_shd, live_vs_snap, last_e;
  assign live_vs_shd  = (|d_live_shd)  || (gain_in != shd_gain_q);
  assign live_vs_snap = (|d_live_snap) || (gain_in != snap_gain_q);
  assign last_e       = (e_q == EW'(NE - 1));

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    shd_d       = shd_q;
    snap_gain_d = snap_gain_q;
    shd_gain_d  = shd_gain_q;
    cnt_d       = cnt_q;
    e_d         = e_q;
    force_d     = force_q | force_all;
    written_d   = written_q;
    wr_valid_d  = wr_valid_q;
    wr_ch_d     = wr_ch_q;
    wr_sel_d    = wr_sel_q;
    wr_data_d   = wr_data_q;
    commit_d    = 1'b0;
    gain_out_d  = gain_out_q;
    case (state_q)
      ST_IDLE: begin
        if (live_vs_shd || force_q) begin
          state_d     = ST_SETTLE;
          snap_d      = live;
          snap_gain_d = gain_in;
          cnt_d       = '0;
        end
      end
      ST_SETTLE: begin
        if (live_vs_snap) begin
          snap_d      = live;
          snap_gain_d = gain_in;
          cnt_d       = '0;
        end else if (cnt_q == 8'(SETTLE - 1)) begin
          e_d     = '0;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SCAN: begin
        if (d_snap_shd[e_q] || force_q) begin
          state_d    = ST_WRITE;
          wr_valid_d = 1'b1;
          wr_ch_d    = CW'(e_q >> 1);
          wr_sel_d   = e_q[0];
          wr_data_d  = snap_q[e_q];
        end else if (last_e) begin
          state_d = ST_COMMIT;
        end else begin
          e_d = e_q + EW'(1);
        end
      end
      ST_WRITE: begin
        if (wr_valid_q && wr_ready) begin
          shd_d[e_q] = snap_q[e_q];
          written_d  = 1'b1;
          wr_valid_d = 1'b0;
          if (last_e) begin
            state_d = ST_COMMIT;
          end else begin
            e_d     = e_q + EW'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_COMMIT: begin
        commit_d   = written_q || (snap_gain_q != shd_gain_q);
        gain_out_d = snap_gain_q;
        shd_gain_d = snap_gain_q;
        written_d  = 1'b0;
        // A pulse landing on this cycle must survive the clear.
        force_d    = force_all;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      shd_q       <= '0;
      snap_gain_q <= '0;
      shd_gain_q  <= '0;
      cnt_q       <= '0;
      e_q         <= '0;
      force_q     <= 1'b0;
      written_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_ch_q     <= '0;
      wr_sel_q    <= 1'b0;
      wr_data_q   <= '0;
      commit_q    <= 1'b0;
      gain_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      shd_q       <= shd_d;
      snap_gain_q <= snap_gain_d;
      shd_gain_q  <= shd_gain_d;
      cnt_q       <= cnt_d;
      e_q         <= e_d;
      force_q     <= force_d;
      written_q   <= written_d;
      wr_valid_q  <= wr_valid_d;
      wr_ch_q     <= wr_ch_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      commit_q    <= commit_d;
      gain_out_q  <= gain_out_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_ch    = wr_ch_q;
  assign wr_sel   = wr_sel_q;
  assign wr_data  = wr_data_q;
  assign commit   = commit_q;
  assign gain_out = gain_out_q;
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_lockin_nco_cfg_scheduler.sv
// Randomized bench for lockin_nco_cfg_scheduler against a shadow/diff reference model.
module tb_lockin_nco_cfg_scheduler;
  localparam int NCH = 8, PW = 20, GW = 6, SETTLE = 4, NE = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*PW-1:0] incr_in, offs_in;
  logic [GW-1:0]     gain_in;
  logic              force_all, wr_ready;
  logic              wr_valid, wr_sel, commit, busy;
  logic [2:0]        wr_ch;
  logic [PW-1:0]     wr_data;
  logic [GW-1:0]     gain_out;

  lockin_nco_cfg_scheduler #(.NCH(NCH), .PW(PW), .GW(GW), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .incr_in(incr_in), .offs_in(offs_in), .gain_in(gain_in),
    .force_all(force_all), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_sel(wr_sel), .wr_data(wr_data), .commit(commit), .gain_out(gain_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, ncommit = 0;
  bit busy_seen = 1'b0;
  logic [23:0] wq[$];
  int wcyc[$];
  logic [GW-1:0] gain_at_commit;
  bit ready_mode = 1'b0;
  logic rdy_val = 1'b1;
  bit pstall = 1'b0;
  logic [24:0] pword;

  logic [PW-1:0] live_m[NE], shadow_m[NE];
  logic [GW-1:0] gain_m, gain_sh;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(input int e, input logic [PW-1:0] d);
    logic [3:0] ev;
    ev = 4'(e);
    return {ev[3:1], ev[0], d};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    wr_ready = ready_mode ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Observer: write handshakes, commits, busy activity, stall stability.
  initial forever begin
    @(negedge clk);
    if (reset) pstall = 1'b0;
    else begin
      if (pstall) chk("hold", {7'd0, wr_valid, wr_ch, wr_sel, wr_data}, {7'd0, pword});
      if (wr_valid && wr_ready) begin
        wq.push_back({wr_ch, wr_sel, wr_data});
        wcyc.push_back(cyc);
      end
      if (commit) begin
        ncommit++;
        gain_at_commit = gain_out;
      end
      if (busy) busy_seen = 1'b1;
      pstall = wr_valid && !wr_ready;
      pword  = {1'b1, wr_ch, wr_sel, wr_data};
    end
  end

  task automatic apply();
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      incr_in[k*PW +: PW] = live_m[2*k];
      offs_in[k*PW +: PW] = live_m[2*k+1];
    end
    gain_in = gain_m;
  endtask

  task automatic pulse_force();
    @(posedge clk);
    #1 force_all = 1'b1;
    @(posedge clk);
    #1 force_all = 1'b0;
  endtask

  task automatic clear_obs();
    wq.delete();
    wcyc.delete();
    ncommit = 0;
    busy_seen = 1'b0;
  endtask

  // Expected activity: entries differing from the model shadow (all when forced), in index order.
  task automatic run_round(input string tag, input bit forced);
    int exp_e[$];
    bit exp_commit;
    int n;
    for (int e = 0; e < NE; e++)
      if (forced || live_m[e] != shadow_m[e]) exp_e.push_back(e);
    exp_commit = (exp_e.size() > 0) || (gain_m != gain_sh);
    repeat (3) @(posedge clk);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      #1;
      if (!busy) break;
      n++;
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_nwr"}, wq.size(), exp_e.size());
    for (int i = 0; i < exp_e.size(); i++)
      if (i < wq.size())
        chk($sformatf("%s_wr%0d", tag, i), {8'd0, wq[i]}, {8'd0, exp_word(exp_e[i], live_m[exp_e[i]])});
    chk({tag, "_ncommit"}, ncommit, exp_commit ? 1 : 0);
    if (exp_commit && ncommit > 0) chk({tag, "_gain_at_commit"}, {26'd0, gain_at_commit}, {26'd0, gain_m});
    chk({tag, "_gain_out"}, {26'd0, gain_out}, {26'd0, gain_m});
    chk({tag, "_busy"}, {31'd0, busy_seen}, {31'd0, exp_commit});
    foreach (exp_e[i]) shadow_m[exp_e[i]] = live_m[exp_e[i]];
    gain_sh = gain_m;
    clear_obs();
  endtask

  initial begin
    int n;
    incr_in = '0; offs_in = '0; gain_in = '0; force_all = 1'b0; wr_ready = 1'b1;
    for (int e = 0; e < NE; e++) begin live_m[e] = '0; shadow_m[e] = '0; end
    gain_m = '0; gain_sh = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, wr_valid}, 0);
    chk("rst_commit", {31'd0, commit}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_word", {8'd0, wr_ch, wr_sel, wr_data}, 0);
    chk("rst_gain", {26'd0, gain_out}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_round("idle", 1'b0);

    live_m[6] = 20'h12345;
    apply();
    run_round("single", 1'b0);
    apply();
    run_round("same", 1'b0);

    for (int i = 0; i < 5; i++) begin
      live_m[15] = 20'h00100 + 20'(i);
      apply();
      @(posedge clk);
    end
    live_m[15] = 20'hABCDE;
    apply();
    n = cyc;
    chk("glitch_nowr", wq.size(), 0);
    for (int t = 0; t < 500 && wq.size() == 0; t++) @(negedge clk);
    chk("glitch_settle", (wq.size() > 0 && wcyc[0] - n >= SETTLE) ? 1 : 0, 1);
    run_round("glitch", 1'b0);

    rdy_val = 1'b0;
    live_m[0]  = 20'h5A5A5;
    live_m[11] = 20'h0F0F1;
    apply();
    n = 0;
    while (!wr_valid && n < 500) begin @(negedge clk); n++; end
    chk("stall_valid", {31'd0, wr_valid}, 1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("stall_hold", {7'd0, wr_valid, wr_ch, wr_sel, wr_data}, {7'd0, 1'b1, exp_word(0, live_m[0])});
    end
    rdy_val = 1'b1;
    run_round("stall", 1'b0);

    gain_m = 6'd17;
    apply();
    run_round("gain", 1'b0);

    for (int e = 0; e < NE; e++) live_m[e] = 20'($urandom) | 20'h1;
    apply();
    run_round("fill", 1'b0);

    pulse_force();
    n = 0;
    while (wq.size() < 5 && n < 3000) begin @(negedge clk); #1; n++; end
    chk("force_5wr", wq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wq.size()) chk($sformatf("force_wr%0d", i), {8'd0, wq[i]}, {8'd0, exp_word(i, live_m[i])});
    reset = 1'b1;
    #1;
    chk("abort_valid", {31'd0, wr_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_gain", {26'd0, gain_out}, 0);
    for (int e = 0; e < NE; e++) shadow_m[e] = '0;
    gain_sh = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_obs();
    run_round("rewrite", 1'b0);

    ready_mode = 1'b1;
    for (int r = 0; r < 30; r++) begin
      bit f;
      int nchg;
      nchg = $urandom_range(0, 3);
      for (int j = 0; j < nchg; j++) live_m[$urandom_range(0, NE-1)] = 20'($urandom);
      if ($urandom_range(0, 2) == 0) gain_m = 6'($urandom);
      f = ($urandom_range(0, 7) == 0);
      apply();
      if (f) pulse_force();
      run_round($sformatf("rnd%0d", r), f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
